// File: rtl/bcast_fifo_if.sv
// bcast_fifo_if: producer/consumer bundle for the broadcast FIFO
interface bcast_fifo_if #(
  parameter int D_WIDTH = 6,
  parameter int DEPTH   = 8,
  parameter int N_RD    = 2
);
  localparam int AW = $clog2(DEPTH);
  logic [D_WIDTH-1:0]        up_data;
  logic                      push;
  logic                      full;
  logic [N_RD*D_WIDTH-1:0]   down_data;
  logic [N_RD-1:0]           pop;
  logic [N_RD-1:0]           empty;
  logic [N_RD*(AW+1)-1:0]    count;
  logic                      ovf;
  logic [N_RD-1:0]           unf;
  modport master (
    output up_data, push, pop,
    input  full, down_data, empty, count, ovf, unf
  );
  modport slave (
    input  up_data, push, pop,
    output full, down_data, empty, count, ovf, unf
  );
endinterface

// File: rtl/bcast_fifo.sv
// bcast_fifo: one-writer, N_RD-reader broadcast FIFO over shared storage; sticky ovf/unf flags only when BCAST_FIFO_ERR_EN is defined
module bcast_fifo #(
  parameter int D_WIDTH = 6,
  parameter int DEPTH   = 8,
  parameter int N_RD    = 2
) (
  input logic        clk,
  input logic        rst,
  bcast_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q [N_RD];
  logic [AW:0] rd_ptr_d [N_RD];
  logic [AW:0] occ [N_RD];
  logic [N_RD-1:0] empty;
  logic full;
  logic wr_en;
  // Flags, counts and show-ahead heads derived purely from registered pointers
  always_comb begin
    full = 1'b0;
    empty = '0;
    bus.down_data = '0;
    bus.count = '0;
    for (int i = 0; i < N_RD; i++) begin
      occ[i] = wr_ptr_q - rd_ptr_q[i];
      empty[i] = (occ[i] == '0);
      full = full | (occ[i] == OCC_FULL);
      bus.count[i*(AW+1) +: AW+1] = occ[i];
      bus.down_data[i*D_WIDTH +: D_WIDTH] = empty[i] ? '0 : mem_q[rd_ptr_q[i][AW-1:0]];
    end
  end
  assign bus.full = full;
  assign bus.empty = empty;
  assign wr_en = bus.push && !full && !rst;
  // Pointer advance: full is sampled before any pop, so a freed slot is usable next cycle
  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + ONE : wr_ptr_q;
    for (int i = 0; i < N_RD; i++)
      rd_ptr_d[i] = (bus.pop[i] && !empty[i]) ? rd_ptr_q[i] + ONE : rd_ptr_q[i];
  end
  // Pointer registers; reset drops all content for every reader at once
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < N_RD; i++) rd_ptr_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      for (int i = 0; i < N_RD; i++) rd_ptr_q[i] <= rd_ptr_d[i];
    end
  end
  // Shared storage, not reset; an entry is only reused once the slowest reader passed it
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= bus.up_data;
  end
`ifdef BCAST_FIFO_ERR_EN
  logic ovf_q;
  logic [N_RD-1:0] unf_q;
  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= '0;
    end else begin
      ovf_q <= ovf_q | (bus.push & full);
      unf_q <= unf_q | (bus.pop & empty);
    end
  end
  assign bus.ovf = ovf_q;
  assign bus.unf = unf_q;
`else
  assign bus.ovf = 1'b0;
  assign bus.unf = '0;
`endif
endmodule

// File: tb/tb_bcast_fifo.sv
// tb_bcast_fifo: directed table and sequence checks for bcast_fifo (DEPTH=4, N_RD=3)
module tb_bcast_fifo;
  localparam int DW = 6;
  localparam int DP = 4;
  localparam int NR = 3;
`ifdef BCAST_FIFO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  typedef struct {
    logic          push;
    logic [DW-1:0] d;
    logic [NR-1:0] pop;
    logic [NR-1:0] e_empty;
    logic          e_full;
    int            c0;
    int            c1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int nchk = 0;
  vec_t tv [11];
  bcast_fifo_if #(.D_WIDTH(DW), .DEPTH(DP), .N_RD(NR)) bus ();
  bcast_fifo #(.D_WIDTH(DW), .DEPTH(DP), .N_RD(NR)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic int dd(input int i);
    return int'(bus.down_data[i*DW +: DW]);
  endfunction
  function automatic int cnt(input int i);
    return int'(bus.count[i*3 +: 3]);
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic p, input logic [DW-1:0] d, input logic [NR-1:0] pp);
    bus.push = p;
    bus.up_data = d;
    bus.pop = pp;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    drive(1'b0, '0, '0);
    tick;
    rst = 1'b0;
  endtask
  task automatic chk_idle(input string n);
    chk({n, " empty"}, int'(bus.empty), 7);
    chk({n, " full"}, int'(bus.full), 0);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s count%0d", n, i), cnt(i), 0);
      chk($sformatf("%s data%0d", n, i), dd(i), 0);
    end
    chk({n, " ovf"}, int'(bus.ovf), 0);
    chk({n, " unf"}, int'(bus.unf), 0);
  endtask
  initial begin
    tv[0]  = '{1'b1, 6'h01, 3'b000, 3'b000, 1'b0, 1, 1, 6'h01, 6'h01};
    tv[1]  = '{1'b1, 6'h02, 3'b000, 3'b000, 1'b0, 2, 2, 6'h01, 6'h01};
    tv[2]  = '{1'b1, 6'h03, 3'b000, 3'b000, 1'b0, 3, 3, 6'h01, 6'h01};
    tv[3]  = '{1'b1, 6'h04, 3'b000, 3'b000, 1'b1, 4, 4, 6'h01, 6'h01};
    tv[4]  = '{1'b1, 6'h05, 3'b001, 3'b000, 1'b1, 3, 4, 6'h02, 6'h01};
    tv[5]  = '{1'b0, 6'h00, 3'b001, 3'b000, 1'b1, 2, 4, 6'h03, 6'h01};
    tv[6]  = '{1'b0, 6'h00, 3'b001, 3'b000, 1'b1, 1, 4, 6'h04, 6'h01};
    tv[7]  = '{1'b0, 6'h00, 3'b001, 3'b001, 1'b1, 0, 4, 6'h00, 6'h01};
    tv[8]  = '{1'b0, 6'h00, 3'b001, 3'b001, 1'b1, 0, 4, 6'h00, 6'h01};
    tv[9]  = '{1'b0, 6'h00, 3'b110, 3'b001, 1'b0, 0, 3, 6'h00, 6'h02};
    tv[10] = '{1'b1, 6'h06, 3'b000, 3'b000, 1'b1, 1, 4, 6'h06, 6'h02};
    drive(1'b0, '0, '0);
    do_reset;
    chk_idle("reset");
    for (int k = 0; k < 11; k++) begin
      drive(tv[k].push, tv[k].d, tv[k].pop);
      tick;
      chk($sformatf("fill%0d empty", k), int'(bus.empty), int'(tv[k].e_empty));
      chk($sformatf("fill%0d full", k), int'(bus.full), int'(tv[k].e_full));
      chk($sformatf("fill%0d count0", k), cnt(0), tv[k].c0);
      chk($sformatf("fill%0d count1", k), cnt(1), tv[k].c1);
      chk($sformatf("fill%0d data0", k), dd(0), int'(tv[k].d0));
      chk($sformatf("fill%0d data1", k), dd(1), int'(tv[k].d1));
    end
    chk("fill ovf", int'(bus.ovf), int'(ERR));
    chk("fill unf", int'(bus.unf), ERR ? 1 : 0);
    do_reset;
    drive(1'b0, '0, 3'b001);
    tick;
    chk("pop_empty empty", int'(bus.empty), 7);
    chk("pop_empty data0", dd(0), 0);
    chk("pop_empty count0", cnt(0), 0);
    chk("pop_empty unf", int'(bus.unf), ERR ? 1 : 0);
    do_reset;
    drive(1'b1, 6'h2A, '0);
    tick;
    drive(1'b0, '0, '0);
    chk("push_empty empty", int'(bus.empty), 0);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("push_empty data%0d", i), dd(i), 'h2A);
      chk($sformatf("push_empty count%0d", i), cnt(i), 1);
    end
    do_reset;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 6'(8'h10 + k), k > 0 ? 3'b011 : 3'b000);
      tick;
      chk($sformatf("slow%0d count2", k), cnt(2), k < 4 ? k + 1 : 4);
    end
    chk("slow full", int'(bus.full), 1);
    chk("slow count0", cnt(0), 0);
    chk("slow ovf", int'(bus.ovf), int'(ERR));
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("slow rd%0d data2", j), dd(2), 'h10 + j);
      drive(1'b0, '0, 3'b100);
      tick;
    end
    drive(1'b0, '0, '0);
    chk("slow drained empty2", int'(bus.empty[2]), 1);
    chk("slow drained full", int'(bus.full), 0);
    do_reset;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 6'(k), k > 0 ? 3'b111 : 3'b000);
      tick;
      chk($sformatf("stream%0d count0", k), cnt(0), 1);
      chk($sformatf("stream%0d data0", k), dd(0), k);
    end
    drive(1'b0, '0, 3'b111);
    tick;
    drive(1'b0, '0, '0);
    chk("stream end empty", int'(bus.empty), 7);
    chk("stream unf", int'(bus.unf), 0);
    do_reset;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 6'(8'h20 + k), '0);
      tick;
    end
    chk("midrst pre count0", cnt(0), 3);
    rst = 1'b1;
    drive(1'b1, 6'h3F, 3'b001);
    tick;
    rst = 1'b0;
    drive(1'b0, '0, '0);
    chk_idle("midrst");
    tick;
    chk("midrst after empty", int'(bus.empty), 7);
    chk("midrst after count0", cnt(0), 0);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
